window_3x3: RTL and testbench

WINDOW_3X3 -- requirements
Module: window_3x3

---
 rtl/window_3x3_pkg.sv | 21 ++
 rtl/window_3x3_line_delay.sv | 36 +++
 rtl/window_3x3.sv | 165 ++++++++++++++++
 tb/tb_window_3x3.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_pkg.sv
// Shared definitions for the 3x3 sliding-window generator: FSM encodings and
// the rule that places window element (r,c) inside the flat output bus.
package window_3x3_pkg;

   typedef enum logic [1:0] {
      ST_FILL0 = 2'd0,
      ST_FILL1 = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int unsigned WIN_DIM   = 3;
   localparam int unsigned WIN_ELEMS = WIN_DIM * WIN_DIM;

   // r=0 is the oldest line, c=0 the oldest column
   function automatic int unsigned win_lsb(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned dw);
      return dw * (WIN_DIM * r + c);
   endfunction

endpackage

// File: rtl/window_3x3_line_delay.sv
// One-line pixel delay: circular RAM, read-first, advancing only on enable.
// Contents are deliberately not reset; only the pointer is.
module line_delay #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 1920
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data_c
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_ptr;

   assign o_data_c = r_mem[r_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_en) begin
         r_ptr <= (r_ptr == PTR_MAX) ? '0 : r_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_mem[r_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/window_3x3.sv
// Streaming 3x3 window generator over a raster pixel stream; emits one window
// per accepted pixel once two full lines and two columns are available.
module window_3x3
   import window_3x3_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned LINE_WIDTH   = 1920,
   parameter int unsigned FRAME_HEIGHT = 1080,
   parameter int unsigned ADDR_WIDTH   = 11
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   input  logic                            in_sof,
   input  logic [DATA_WIDTH-1:0]           in_data,
   output logic                            out_valid,
   output logic [WIN_ELEMS*DATA_WIDTH-1:0] out_window,
   output logic [ADDR_WIDTH-1:0]           out_x,
   output logic [ADDR_WIDTH-1:0]           out_y,
   output logic                            out_last
);

   localparam int unsigned WIN_W = WIN_ELEMS * DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] X_MAX = ADDR_WIDTH'(LINE_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] Y_MAX = ADDR_WIDTH'(FRAME_HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO   = ADDR_WIDTH'(2);

   state_t                              r_state;
   state_t                              w_state_cur;
   state_t                              w_state_nxt;
   logic [ADDR_WIDTH-1:0]               r_x;
   logic [ADDR_WIDTH-1:0]               r_y;
   logic [ADDR_WIDTH-1:0]               w_x_cur;
   logic [ADDR_WIDTH-1:0]               w_y_cur;
   logic                                w_x_end;
   logic                                w_y_end;
   logic                                w_emit;
   logic [DATA_WIDTH-1:0]               w_tap1;
   logic [DATA_WIDTH-1:0]               w_tap2;
   logic [WIN_DIM-1:0][DATA_WIDTH-1:0]  w_col;
   logic [WIN_DIM-1:0][DATA_WIDTH-1:0]  r_c0;
   logic [WIN_DIM-1:0][DATA_WIDTH-1:0]  r_c1;
   logic [WIN_W-1:0]                    w_win;

   // An accepted SOF is pixel (0,0) in FILL0 whatever the counters say
   assign w_x_cur = in_sof ? '0 : r_x;
   assign w_y_cur = in_sof ? '0 : r_y;
   assign w_x_end = (w_x_cur == X_MAX);
   assign w_y_end = (w_y_cur == Y_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (in_valid) begin
         if (w_x_end) begin
            r_x <= '0;
            r_y <= w_y_end ? '0 : w_y_cur + ONE;
         end else begin
            r_x <= w_x_cur + ONE;
            r_y <= w_y_cur;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FILL0;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_cur = in_sof ? ST_FILL0 : r_state;
      w_state_nxt = r_state;
      if (in_valid) begin
         w_state_nxt = w_state_cur;
         if (w_x_end) begin
            case (w_state_cur)
               ST_FILL0: w_state_nxt = ST_FILL1;
               ST_FILL1: w_state_nxt = ST_RUN;
               ST_RUN:   w_state_nxt = w_y_end ? ST_FILL0 : ST_RUN;
               default:  w_state_nxt = ST_FILL0;
            endcase
         end
      end
   end

   always_comb begin
      w_emit = 1'b0;
      if (in_valid && (w_state_cur == ST_RUN) && (w_x_cur >= TWO)) begin
         w_emit = 1'b1;
      end
   end

   line_delay #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (LINE_WIDTH)
   ) u_ld0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (in_valid),
      .i_data   (in_data),
      .o_data_c (w_tap1)
   );

   line_delay #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (LINE_WIDTH)
   ) u_ld1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (in_valid),
      .i_data   (w_tap1),
      .o_data_c (w_tap2)
   );

   // Incoming column, oldest line in row 0
   assign w_col = {in_data, w_tap1, w_tap2};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c0 <= '0;
         r_c1 <= '0;
      end else if (in_valid) begin
         r_c0 <= r_c1;
         r_c1 <= w_col;
      end
   end

   for (genvar gr = 0; gr < WIN_DIM; gr++) begin : g_row
      for (genvar gc = 0; gc < WIN_DIM; gc++) begin : g_col
         localparam int unsigned LSB = win_lsb(gr, gc, DATA_WIDTH);
         if (gc == 0) begin : g_c0
            assign w_win[LSB +: DATA_WIDTH] = r_c0[gr];
         end else if (gc == 1) begin : g_c1
            assign w_win[LSB +: DATA_WIDTH] = r_c1[gr];
         end else begin : g_c2
            assign w_win[LSB +: DATA_WIDTH] = w_col[gr];
         end
      end
   end

   // Payload only loads with a valid window, so it holds across gaps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_window <= '0;
         out_x      <= '0;
         out_y      <= '0;
         out_last   <= 1'b0;
      end else begin
         out_valid <= w_emit;
         if (w_emit) begin
            out_window <= w_win;
            out_x      <= w_x_cur - ONE;
            out_y      <= w_y_cur - ONE;
            out_last   <= w_x_end && w_y_end;
         end
      end
   end

endmodule

// File: tb/tb_window_3x3.sv
// Scoreboard bench for window_3x3 on an 8x6 frame with pixel value 16*y+x
// (optionally XOR-tagged to tell frames apart).
module tb_window_3x3;

   localparam int unsigned DW = 8;
   localparam int unsigned LW = 8;
   localparam int unsigned FH = 6;
   localparam int unsigned AW = 11;

   typedef struct packed {
      logic [9*DW-1:0] win;
      logic [AW-1:0]   x;
      logic [AW-1:0]   y;
      logic            last;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_sof;
   logic [DW-1:0]   in_data;
   logic            out_valid;
   logic [9*DW-1:0] out_window;
   logic [AW-1:0]   out_x;
   logic [AW-1:0]   out_y;
   logic            out_last;

   int n_cmp;
   int n_bad;
   int win_cnt;
   int bx;
   int by;
   exp_t          q[$];
   logic [DW-1:0] mdl [FH][LW];
   logic          acc_q;

   window_3x3 #(
      .DATA_WIDTH   (DW),
      .LINE_WIDTH   (LW),
      .FRAME_HEIGHT (FH),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_window (out_window),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_last   (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= 1'b0;
      else        acc_q <= in_valid;
   end

   // Window around centre (cx,cy), computed from coordinates alone
   function automatic logic [9*DW-1:0] const_win(input int cx, input int cy,
                                                 input logic [DW-1:0] tag);
      logic [9*DW-1:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[DW*(3*r+c) +: DW] = DW'(16*(cy-1+r) + (cx-1+c)) ^ tag;
      return w;
   endfunction

   // Drive one accepted pixel; model pushes the window it must produce
   task automatic px(input logic sof, input logic [DW-1:0] tag);
      int   cx;
      int   cy;
      exp_t e;
      cx = sof ? 0 : bx;
      cy = sof ? 0 : by;
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = DW'(16*cy + cx) ^ tag;
      mdl[cy][cx] = in_data;
      if (cx >= 2 && cy >= 2) begin
         e.win = '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               e.win[DW*(3*r+c) +: DW] = mdl[cy-2+r][cx-2+c];
         e.x    = AW'(cx - 1);
         e.y    = AW'(cy - 1);
         e.last = (cx == LW-1) && (cy == FH-1);
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
      if (cx == LW-1) begin
         bx = 0;
         by = (cy == FH-1) ? 0 : cy + 1;
      end else begin
         bx = cx + 1;
         by = cy;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Scoreboard monitor: pops on every out_valid, checks hold otherwise
   initial begin : monitor
      logic [9*DW-1:0] l_win;
      logic [AW-1:0]   l_x;
      logic [AW-1:0]   l_y;
      logic            l_last;
      exp_t            e;
      l_win = '0; l_x = '0; l_y = '0; l_last = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            l_win = out_window; l_x = out_x; l_y = out_y; l_last = out_last;
         end else if (out_valid === 1'b1) begin
            win_cnt++;
            n_cmp++;
            if (acc_q !== 1'b1) begin
               n_bad++;
               $display("FAIL adjacency: out_valid=1 but accept on previous edge=%b, required 1", acc_q);
            end
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL spurious_window: got x=%0d y=%0d win=%h, required no window", out_x, out_y, out_window);
            end else begin
               e = q.pop_front();
               if ({out_window, out_x, out_y, out_last} !== {e.win, e.x, e.y, e.last}) begin
                  n_bad++;
                  $display("FAIL window: got win=%h x=%0d y=%0d last=%b, required win=%h x=%0d y=%0d last=%b",
                           out_window, out_x, out_y, out_last, e.win, e.x, e.y, e.last);
               end
            end
            l_win = out_window; l_x = out_x; l_y = out_y; l_last = out_last;
         end else begin
            n_cmp++;
            if ({out_valid, out_window, out_x, out_y, out_last} !== {1'b0, l_win, l_x, l_y, l_last}) begin
               n_bad++;
               $display("FAIL hold: got v=%b win=%h x=%0d y=%0d last=%b, required v=0 win=%h x=%0d y=%0d last=%b",
                        out_valid, out_window, out_x, out_y, out_last, l_win, l_x, l_y, l_last);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
      bx = 0; by = 0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
      n_cmp++; if (out_window !== '0) begin n_bad++; $display("FAIL reset_window: got %h, required 0", out_window); end
      n_cmp++; if (out_x !== '0) begin n_bad++; $display("FAIL reset_x: got %0d, required 0", out_x); end
      n_cmp++; if (out_y !== '0) begin n_bad++; $display("FAIL reset_y: got %0d, required 0", out_y); end
      n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b, required 0", out_last); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_contiguous();
      win_cnt = 0;
      for (int i = 0; i < int'(LW*FH); i++) begin
         px(1'b0, '0);
         if (i == int'(2*LW + 2)) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %b, required 1", out_valid); end
            n_cmp++; if (out_window !== const_win(1, 1, '0)) begin n_bad++; $display("FAIL first_window: got %h, required %h", out_window, const_win(1, 1, '0)); end
            n_cmp++; if (out_x !== AW'(1) || out_y !== AW'(1)) begin n_bad++; $display("FAIL first_xy: got (%0d,%0d), required (1,1)", out_x, out_y); end
         end
      end
      idle(3);
      n_cmp++; if (win_cnt !== 24) begin n_bad++; $display("FAIL contig_count: got %0d, required 24", win_cnt); end
      n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL contig_pending: got %0d, required 0", q.size()); end
   endtask

   task automatic test_gaps();
      win_cnt = 0;
      for (int i = 0; i < int'(LW*FH); i++) begin
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
         px(1'b0, '0);
      end
      idle(3);
      n_cmp++; if (win_cnt !== 24) begin n_bad++; $display("FAIL gaps_count: got %0d, required 24", win_cnt); end
      n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL gaps_pending: got %0d, required 0", q.size()); end
   endtask

   task automatic test_sof_mid();
      for (int i = 0; i < int'(3*LW + 5); i++) px(1'b0, '0);
      idle(2);
      win_cnt = 0;
      for (int i = 0; i < int'(LW*FH); i++) begin
         px(i == 0, 8'h80);
         if (i == int'(2*LW + 2)) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_window !== const_win(1, 1, 8'h80)) begin
               n_bad++;
               $display("FAIL sof_first_window: got v=%b %h, required v=1 %h", out_valid, out_window, const_win(1, 1, 8'h80));
            end
         end
      end
      idle(3);
      n_cmp++; if (win_cnt !== 24) begin n_bad++; $display("FAIL sof_count: got %0d, required 24", win_cnt); end
      n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL sof_pending: got %0d, required 0", q.size()); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < int'(3*LW + 3); i++) px(1'b0, 8'h80);
      idle(2);
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_cmp++; if ({out_valid, out_window, out_x, out_y, out_last} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got v=%b win=%h x=%0d y=%0d last=%b, required all 0",
                     out_valid, out_window, out_x, out_y, out_last);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      bx = 0; by = 0;
      q.delete();
      win_cnt = 0;
      for (int i = 0; i < int'(LW*FH); i++) begin
         px(1'b0, '0);
         if (i == int'(2*LW + 2)) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_window !== const_win(1, 1, '0)) begin
               n_bad++;
               $display("FAIL midreset_first_window: got v=%b %h, required v=1 %h", out_valid, out_window, const_win(1, 1, '0));
            end
         end
      end
      idle(3);
      n_cmp++; if (win_cnt !== 24) begin n_bad++; $display("FAIL midreset_count: got %0d, required 24", win_cnt); end
   endtask

   task automatic test_back_to_back();
      win_cnt = 0;
      for (int i = 0; i < int'(2*LW*FH); i++) begin
         px(i == 0, '0);
         if (i == int'(LW*FH - 1)) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin n_bad++; $display("FAIL last_flag: got v=%b last=%b, required 1/1", out_valid, out_last); end
            n_cmp++; if (out_x !== AW'(6) || out_y !== AW'(4)) begin n_bad++; $display("FAIL last_xy: got (%0d,%0d), required (6,4)", out_x, out_y); end
            n_cmp++; if (out_window !== const_win(6, 4, '0)) begin n_bad++; $display("FAIL last_window: got %h, required %h", out_window, const_win(6, 4, '0)); end
         end
      end
      idle(3);
      n_cmp++; if (win_cnt !== 48) begin n_bad++; $display("FAIL b2b_count: got %0d, required 48", win_cnt); end
      n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL b2b_pending: got %0d, required 0", q.size()); end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      win_cnt = 0;
      test_reset();
      test_contiguous();
      test_gaps();
      test_sof_mid();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
